rop_req_gen: RTL and testbench



---
 rtl/rop_req_gen_pkg.sv | 56 +++++
 rtl/rop_req_gen_addr_calc.sv | 26 ++
 rtl/rop_req_gen.sv | 153 +++++++++++++++
 tb/tb_rop_req_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rop_req_gen_pkg.sv
// Shared ROP types: DCR view, queue entry, per-fragment request, and the lane picker.
package rop_req_gen_pkg;

    localparam int NUM_THREADS       = 4;
    localparam int ROP_DIM_BITS      = 16;
    localparam int ROP_DEPTH_BITS    = 24;
    localparam int ROP_REQ_LANE_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef struct packed {
        logic [31:0] cbuf_addr;
        logic [31:0] cbuf_pitch;
        logic [31:0] zbuf_addr;
        logic [31:0] zbuf_pitch;
        logic        depth_enable;
        logic        stencil_front_enable;
        logic        stencil_back_enable;
    } rop_dcrs_t;

    typedef struct packed {
        logic [NUM_THREADS-1:0]                     tmask;
        logic [NUM_THREADS-1:0][ROP_DIM_BITS-1:0]   pos_x;
        logic [NUM_THREADS-1:0][ROP_DIM_BITS-1:0]   pos_y;
        logic [NUM_THREADS-1:0][31:0]               color;
        logic [NUM_THREADS-1:0][ROP_DEPTH_BITS-1:0] depth;
        logic                                       backface;
    } rop_queue_entry;

    typedef struct packed {
        logic [ROP_REQ_LANE_BITS-1:0] lane;
        logic [ROP_DIM_BITS-1:0]      pos_x;
        logic [ROP_DIM_BITS-1:0]      pos_y;
        logic [31:0]                  color;
        logic [ROP_DEPTH_BITS-1:0]    depth;
        logic                         backface;
        logic [31:0]                  cbuf_addr;
        logic [31:0]                  zbuf_addr;
        logic                         zbuf_en;
        logic                         last;
    } rop_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rop_req_state_e;

    // Fixed-priority encoder: index of the lowest set bit, 0 for an empty mask.
    function automatic logic [ROP_REQ_LANE_BITS-1:0] rop_lowest_lane(input logic [NUM_THREADS-1:0] mask);
        rop_lowest_lane = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                rop_lowest_lane = ROP_REQ_LANE_BITS'(i);
            end
        end
    endfunction

endpackage

// File: rtl/rop_req_gen_addr_calc.sv
// Surface byte address: base + y*pitch + (x<<2), everything modulo 2^32.
// Latency: combinational. Backpressure: none, pure datapath.
module rop_addr_calc
    import rop_req_gen_pkg::*;
#(
    parameter int DIM_BITS = ROP_DIM_BITS
) (
    input  logic [31:0]         base,
    input  logic [31:0]         pitch,
    input  logic [DIM_BITS-1:0] pos_x,
    input  logic [DIM_BITS-1:0] pos_y,
    output logic [31:0]         addr
);

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic [31:0] row_off;

    always_comb begin
        x_ext   = 32'(pos_x);
        y_ext   = 32'(pos_y);
        row_off = y_ext * pitch;
        addr    = base + row_off + (x_ext << 2);
    end

endmodule

// File: rtl/rop_req_gen.sv
// Serializes a warp-wide ROP queue entry into one memory request per active lane.
// Latency: first request one cycle after accept, then one per cycle; next entry reloads on the last handshake.
// Backpressure: out_ready low freezes the held request; in_ready only in IDLE or on the last handshake.
// Depth/stencil addressing is present only when ROP_REQ_ZBUF_EN is defined.
module rop_req_gen
    import rop_req_gen_pkg::*;
#(
    parameter int NUM_LANES  = NUM_THREADS,
    parameter int DIM_BITS   = ROP_DIM_BITS,
    parameter int DEPTH_BITS = ROP_DEPTH_BITS
) (
    input  logic           clk,
    input  logic           reset,
    input  rop_dcrs_t      dcrs,
    input  logic           in_valid,
    output logic           in_ready,
    input  rop_queue_entry in_entry,
    output logic           out_valid,
    input  logic           out_ready,
    output rop_req_t       out_req
);

    rop_req_state_e        state_q, state_d;
    logic [NUM_LANES-1:0]  pending_q, pending_d;
    rop_queue_entry        entry_q, entry_d;
    rop_dcrs_t             dcrs_q, dcrs_d;
    rop_req_t              out_req_q, out_req_d;

    logic                  out_fire;
    logic                  accept;
    logic [NUM_LANES-1:0]  pending_after;

    rop_queue_entry        src_entry;
    rop_dcrs_t             src_dcrs;
    logic [NUM_LANES-1:0]  src_pend;
    logic [ROP_REQ_LANE_BITS-1:0] src_lane;
    logic                  src_last;
    logic [31:0]           cbuf_addr_w;
    logic [31:0]           zbuf_addr_w;
    logic                  zbuf_en_w;
    rop_req_t              req_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            entry_q   <= '0;
            dcrs_q    <= '0;
            out_req_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            entry_q   <= entry_d;
            dcrs_q    <= dcrs_d;
            out_req_q <= out_req_d;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_ISSUE);
        out_fire  = out_valid && out_ready;
        in_ready  = (state_q == ST_IDLE) || (out_fire && out_req_q.last);
        accept    = in_valid && in_ready;
        out_req   = out_req_q;
    end

    // The next request is built from the incoming entry on a reload, else from the held one.
    always_comb begin
        pending_after = pending_q & ~(NUM_LANES'(1) << out_req_q.lane);
        src_entry     = entry_q;
        src_dcrs      = dcrs_q;
        src_pend      = pending_after;
        if (accept) begin
            src_entry = in_entry;
            src_dcrs  = dcrs;
            src_pend  = in_entry.tmask;
        end
        src_lane = rop_lowest_lane(src_pend);
        src_last = ((src_pend & ~(NUM_LANES'(1) << src_lane)) == '0);
    end

    rop_addr_calc #(.DIM_BITS(DIM_BITS)) u_cbuf_addr (
        .base  (src_dcrs.cbuf_addr),
        .pitch (src_dcrs.cbuf_pitch),
        .pos_x (src_entry.pos_x[src_lane]),
        .pos_y (src_entry.pos_y[src_lane]),
        .addr  (cbuf_addr_w)
    );

`ifdef ROP_REQ_ZBUF_EN
    rop_addr_calc #(.DIM_BITS(DIM_BITS)) u_zbuf_addr (
        .base  (src_dcrs.zbuf_addr),
        .pitch (src_dcrs.zbuf_pitch),
        .pos_x (src_entry.pos_x[src_lane]),
        .pos_y (src_entry.pos_y[src_lane]),
        .addr  (zbuf_addr_w)
    );
    assign zbuf_en_w = src_dcrs.depth_enable | src_dcrs.stencil_front_enable
                     | src_dcrs.stencil_back_enable;
`else
    logic unused_zbuf_dcrs;
    assign zbuf_addr_w      = '0;
    assign zbuf_en_w        = 1'b0;
    assign unused_zbuf_dcrs = ^{src_dcrs.zbuf_addr, src_dcrs.zbuf_pitch, src_dcrs.depth_enable,
                                src_dcrs.stencil_front_enable, src_dcrs.stencil_back_enable};
`endif

    logic unused_held_tmask;
    assign unused_held_tmask = ^src_entry.tmask;

    always_comb begin
        req_next           = '0;
        req_next.lane      = src_lane;
        req_next.pos_x     = src_entry.pos_x[src_lane];
        req_next.pos_y     = src_entry.pos_y[src_lane];
        req_next.color     = src_entry.color[src_lane];
        req_next.depth     = DEPTH_BITS'(src_entry.depth[src_lane]);
        req_next.backface  = src_entry.backface;
        req_next.cbuf_addr = cbuf_addr_w;
        req_next.zbuf_addr = zbuf_addr_w;
        req_next.zbuf_en   = zbuf_en_w;
        req_next.last      = src_last;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        entry_d   = entry_q;
        dcrs_d    = dcrs_q;
        out_req_d = out_req_q;
        if (accept) begin
            if (in_entry.tmask != '0) begin
                state_d   = ST_ISSUE;
                pending_d = in_entry.tmask;
                entry_d   = in_entry;
                dcrs_d    = dcrs;
                out_req_d = req_next;
            end else begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        end else if (out_fire) begin
            if (out_req_q.last) begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end else begin
                pending_d = pending_after;
                out_req_d = req_next;
            end
        end
    end

endmodule

// File: tb/tb_rop_req_gen.sv
// Directed bench for rop_req_gen: table of single-entry vectors plus hand sequences
// for back-to-back reload, empty mask, stall with DCR change, and mid-issue reset.
module tb_rop_req_gen;
    import rop_req_gen_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    rop_dcrs_t      dcrs;
    logic           in_valid;
    logic           in_ready;
    rop_queue_entry in_entry;
    logic           out_valid;
    logic           out_ready;
    rop_req_t       out_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rop_req_gen dut (
        .clk       (clk),
        .reset     (reset),
        .dcrs      (dcrs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_req   (out_req)
    );

    typedef struct packed {
        logic [31:0]      cb;
        logic [31:0]      cp;
        logic [31:0]      zb;
        logic [31:0]      zp;
        logic [2:0]       en;    // {stencil_back, stencil_front, depth}
        logic [3:0]       tm;
        logic [3:0][15:0] px;
        logic [3:0][15:0] py;
        logic [2:0]       n;
        logic [3:0][1:0]  lane;
        logic [3:0][31:0] ecb;
        logic [3:0][31:0] ezb;
        logic             ezen;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] zexp(input logic [31:0] v);
`ifdef ROP_REQ_ZBUF_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    function automatic logic zen_exp(input logic v);
`ifdef ROP_REQ_ZBUF_EN
        return v;
`else
        return (v & 1'b0);
`endif
    endfunction

    function automatic rop_dcrs_t mk_dcrs(input logic [31:0] cb, input logic [31:0] cp,
                                          input logic [31:0] zb, input logic [31:0] zp,
                                          input logic [2:0] en);
        rop_dcrs_t d;
        d.cbuf_addr            = cb;
        d.cbuf_pitch           = cp;
        d.zbuf_addr            = zb;
        d.zbuf_pitch           = zp;
        d.depth_enable         = en[0];
        d.stencil_front_enable = en[1];
        d.stencil_back_enable  = en[2];
        return d;
    endfunction

    function automatic rop_queue_entry mk_entry(input logic [3:0] tm, input logic [3:0][15:0] px,
                                                input logic [3:0][15:0] py);
        rop_queue_entry e;
        e          = '0;
        e.tmask    = tm;
        e.pos_x    = px;
        e.pos_y    = py;
        e.backface = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.color[i] = 32'hC0DE_0000 | 32'(i);
            e.depth[i] = 24'hD0_0000 | 24'(i);
        end
        return e;
    endfunction

    task automatic check_req(input string tag, input logic [1:0] lane, input logic [31:0] cb,
                             input logic [31:0] zb, input logic zen, input logic last);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".lane"},  64'(out_req.lane), 64'(lane));
        chk({tag, ".cbuf"},  64'(out_req.cbuf_addr), 64'(cb));
        chk({tag, ".zbuf"},  64'(out_req.zbuf_addr), 64'(zexp(zb)));
        chk({tag, ".zen"},   64'(out_req.zbuf_en), 64'(zen_exp(zen)));
        chk({tag, ".last"},  64'(out_req.last), 64'(last));
        chk({tag, ".color"}, 64'(out_req.color), 64'(32'hC0DE_0000 | 32'(lane)));
        chk({tag, ".depth"}, 64'(out_req.depth), 64'(24'hD0_0000 | 24'(lane)));
        chk({tag, ".bf"},    64'(out_req.backface), 64'(1'b1));
    endtask

    logic [3:0][15:0] bp_px;
    logic [3:0][15:0] bp_py;
    logic [31:0]      bp_cb[4];
    logic [31:0]      bp_zb[4];

    initial begin
        reset     = 1'b1;
        dcrs      = '0;
        in_valid  = 1'b0;
        in_entry  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bp_px[i] = 16'(i);
            bp_py[i] = 16'(i + 1);
        end
        bp_cb = '{32'h1400, 32'h1804, 32'h1C08, 32'h200C};
        bp_zb = '{32'h8200, 32'h8404, 32'h8608, 32'h880C};

        // single lane: (3,2) -> 0x180C / 0x840C
        vecs[0] = '0;
        vecs[0].cb = 32'h1000; vecs[0].cp = 32'h400; vecs[0].zb = 32'h8000; vecs[0].zp = 32'h200;
        vecs[0].en = 3'b001; vecs[0].tm = 4'b0001; vecs[0].px[0] = 16'd3; vecs[0].py[0] = 16'd2;
        vecs[0].n = 3'd1; vecs[0].lane[0] = 2'd0; vecs[0].ecb[0] = 32'h180C; vecs[0].ezb[0] = 32'h840C;
        vecs[0].ezen = 1'b1;
        // sparse mask 1010: lane1 (5,1), lane3 (0,7)
        vecs[1] = vecs[0];
        vecs[1].tm = 4'b1010; vecs[1].px = '0; vecs[1].py = '0;
        vecs[1].px[1] = 16'd5; vecs[1].py[1] = 16'd1; vecs[1].px[3] = 16'd0; vecs[1].py[3] = 16'd7;
        vecs[1].n = 3'd2; vecs[1].lane[0] = 2'd1; vecs[1].lane[1] = 2'd3;
        vecs[1].ecb[0] = 32'h1414; vecs[1].ezb[0] = 32'h8214;
        vecs[1].ecb[1] = 32'h2C00; vecs[1].ezb[1] = 32'h8E00;
        // 32-bit wraparound of base + product; stencil_back alone enables z
        vecs[2] = '0;
        vecs[2].cb = 32'hFFFF_FFF0; vecs[2].cp = 32'h10; vecs[2].zb = 32'h0; vecs[2].zp = 32'h1000_0000;
        vecs[2].en = 3'b100; vecs[2].tm = 4'b0100; vecs[2].px[2] = 16'd4; vecs[2].py[2] = 16'h20;
        vecs[2].n = 3'd1; vecs[2].lane[0] = 2'd2; vecs[2].ecb[0] = 32'h0000_0200; vecs[2].ezb[0] = 32'h10;
        vecs[2].ezen = 1'b1;
        // max coordinates must zero-extend; no z enables
        vecs[3] = '0;
        vecs[3].cb = 32'h0; vecs[3].cp = 32'h1_0000; vecs[3].zb = 32'h100; vecs[3].zp = 32'h0;
        vecs[3].en = 3'b000; vecs[3].tm = 4'b0001; vecs[3].px[0] = 16'hFFFF; vecs[3].py[0] = 16'hFFFF;
        vecs[3].n = 3'd1; vecs[3].lane[0] = 2'd0; vecs[3].ecb[0] = 32'h0002_FFFC; vecs[3].ezb[0] = 32'h0004_00FC;
        vecs[3].ezen = 1'b0;

        #2;
        chk("rst.in_ready",  64'(in_ready), 64'(1'b1));
        chk("rst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst.out_req",   64'(out_req == '0), 64'(1'b1));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            dcrs     = mk_dcrs(vecs[v].cb, vecs[v].cp, vecs[v].zb, vecs[v].zp, vecs[v].en);
            in_entry = mk_entry(vecs[v].tm, vecs[v].px, vecs[v].py);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d.in_ready", v), 64'(in_ready), 64'(1'b1));
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                @(negedge clk);
                check_req($sformatf("tbl%0d.r%0d", v, k), vecs[v].lane[k], vecs[v].ecb[k],
                          vecs[v].ezb[k], vecs[v].ezen, k == int'(vecs[v].n) - 1);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d.drain", v), 64'(out_valid), 64'(1'b0));
            @(posedge clk); #1;
        end

        // back-to-back: sparse entry then a single-lane entry reloaded on the last handshake
        dcrs     = mk_dcrs(32'h1000, 32'h400, 32'h8000, 32'h200, 3'b001);
        in_entry = mk_entry(vecs[1].tm, vecs[1].px, vecs[1].py);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_entry = mk_entry(vecs[0].tm, vecs[0].px, vecs[0].py);
        @(negedge clk);
        check_req("b2b.a0", 2'd1, 32'h1414, 32'h8214, 1'b1, 1'b0);
        chk("b2b.rdy_mid", 64'(in_ready), 64'(1'b0));
        @(posedge clk); #1;
        @(negedge clk);
        check_req("b2b.a1", 2'd3, 32'h2C00, 32'h8E00, 1'b1, 1'b1);
        chk("b2b.rdy_last", 64'(in_ready), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_req("b2b.b0", 2'd0, 32'h180C, 32'h840C, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.drain", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;

        // empty mask is swallowed
        in_entry = mk_entry(4'b0000, vecs[0].px, vecs[0].py);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("empty%0d.in_ready", c), 64'(in_ready), 64'(1'b1));
            chk($sformatf("empty%0d.valid", c), 64'(out_valid), 64'(1'b0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("empty.after", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;

        // stall 5 cycles with a DCR change; addresses come from the accept-time snapshot
        out_ready = 1'b0;
        in_entry  = mk_entry(4'b1111, bp_px, bp_py);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_req($sformatf("stall%0d", c), 2'd0, bp_cb[0], bp_zb[0], 1'b1, 1'b0);
            chk($sformatf("stall%0d.in_ready", c), 64'(in_ready), 64'(1'b0));
            @(posedge clk); #1;
            if (c == 1) dcrs = mk_dcrs(32'hDEAD_0000, 32'h400, 32'hBEEF_0000, 32'h200, 3'b000);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_req($sformatf("bp.r%0d", k), 2'(k), bp_cb[k], bp_zb[k], 1'b1, k == 3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp.drain", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;

        // reset after the second of four requests
        dcrs     = mk_dcrs(32'h1000, 32'h400, 32'h8000, 32'h200, 3'b001);
        in_entry = mk_entry(4'b1111, bp_px, bp_py);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_req("rmid.r0", 2'd0, bp_cb[0], bp_zb[0], 1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_req("rmid.r1", 2'd1, bp_cb[1], bp_zb[1], 1'b1, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rmid.valid", 64'(out_valid), 64'(1'b0));
        chk("rmid.in_ready", 64'(in_ready), 64'(1'b1));
        chk("rmid.out_req", 64'(out_req == '0), 64'(1'b1));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmid.idle", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_req($sformatf("post.r%0d", k), 2'(k), bp_cb[k], bp_zb[k], 1'b1, k == 3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("post.drain", 64'(out_valid), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
